// File: rtl/pov_spi_master.sv
// Byte-stream SPI master (mode 0) for a POV display: MSB-first shifting with a
// one-entry holding register so back-to-back bytes stream without sck gaps.
module pov_spi_master #(
    parameter int unsigned HALF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy,
    output logic       cs_n,
    output logic       sck,
    output logic       mosi
);

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, HOLD, GAP} state_t;

    // Phase counter spans a full bit (2*HALF cycles); 9 bits covers HALF=255.
    localparam logic [8:0] PH_LAST   = 9'(2 * HALF - 1);
    localparam logic [8:0] HOLD_LAST = 9'(HALF - 1);
    localparam logic [8:0] HALF_P    = 9'(HALF);

    state_t     state_q, state_d;
    logic [8:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_valid_q, hold_valid_d;
    logic       tx_ready_q, tx_ready_d;
    logic       busy_q, busy_d;
    logic       cs_n_q, cs_n_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;

    logic hs;
    logic end_phase;
    logic byte_end;
    logic drive_line;

    assign hs        = tx_valid & tx_ready_q;
    assign end_phase = (phase_q == PH_LAST);
    assign byte_end  = end_phase && (bit_q == 3'd0);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        last_d       = last_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    phase_d = 9'd0;
                    bit_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!byte_end) begin
                    if (end_phase) begin
                        phase_d = 9'd0;
                        bit_d   = 3'(bit_q - 3'd1);
                    end else begin
                        phase_d = 9'(phase_q + 9'd1);
                    end
                    if (hs) begin
                        hold_data_d  = tx_data;
                        hold_last_d  = tx_last;
                        hold_valid_d = 1'b1;
                    end
                end else if (last_q) begin
                    state_d = HOLD;
                    phase_d = 9'd0;
                    if (hs) begin
                        hold_data_d  = tx_data;
                        hold_last_d  = tx_last;
                        hold_valid_d = 1'b1;
                    end
                end else if (hold_valid_q) begin
                    // Holding byte moves up while a same-cycle handshake refills holding.
                    shift_d = hold_data_q;
                    last_d  = hold_last_q;
                    phase_d = 9'd0;
                    bit_d   = 3'd7;
                    if (hs) begin
                        hold_data_d = tx_data;
                        hold_last_d = tx_last;
                    end else begin
                        hold_valid_d = 1'b0;
                    end
                end else if (hs) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    phase_d = 9'd0;
                    bit_d   = 3'd7;
                end else begin
                    state_d = WAIT;
                    phase_d = 9'd0;
                end
            end
            WAIT: begin
                if (hs) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    phase_d = 9'd0;
                    bit_d   = 3'd7;
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    state_d = GAP;
                    phase_d = 9'd0;
                end else begin
                    phase_d = 9'(phase_q + 9'd1);
                end
            end
            GAP: begin
                if (end_phase) begin
                    phase_d = 9'd0;
                    if (hold_valid_q) begin
                        shift_d      = hold_data_q;
                        last_d       = hold_last_q;
                        hold_valid_d = 1'b0;
                        bit_d        = 3'd7;
                        state_d      = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = 9'(phase_q + 9'd1);
                end
            end
            default: begin
                state_d      = IDLE;
                phase_d      = 9'd0;
                bit_d        = 3'd0;
                hold_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state; tx_ready also opens on the
    // last cycle of a non-final byte so a new byte can replace the one moving up.
    always_comb begin
        drive_line = (state_d == SHIFT) || (state_d == WAIT) || (state_d == HOLD);
        cs_n_d     = !drive_line;
        sck_d      = (state_d == SHIFT) && (phase_d >= HALF_P);
        mosi_d     = drive_line ? shift_d[bit_d] : 1'b0;
        busy_d     = (state_d != IDLE);
        tx_ready_d = 1'b0;
        case (state_d)
            IDLE:    tx_ready_d = 1'b1;
            SHIFT:   tx_ready_d = !hold_valid_d ||
                                  ((phase_d == PH_LAST) && (bit_d == 3'd0) && !last_d);
            WAIT:    tx_ready_d = !hold_valid_d;
            default: tx_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            phase_q      <= 9'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            last_q       <= 1'b0;
            hold_data_q  <= 8'd0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
            cs_n_q       <= cs_n_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign cs_n     = cs_n_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_pov_spi_master.sv
// Bench for pov_spi_master: a scoreboard of expected bytes is drained by a line
// monitor that deserialises mosi at rising sck edges; directed timing checks plus random streams.
module tb_pov_spi_master;

    localparam int HALF     = 2;
    localparam int BYTE_CYC = 16 * HALF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       cs_n;
    logic       sck;
    logic       mosi;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [8:0] exp_q[$];
    int         rise_q[$];
    int         cs_fall_cyc = -1;
    int         cs_rise_cyc = -1;
    int         fall_cnt = 0;

    pov_spi_master #(.HALF(HALF)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .busy     (busy),
        .cs_n     (cs_n),
        .sck      (sck),
        .mosi     (mosi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Line monitor: rebuilds bytes from the wire and checks them against the scoreboard.
    int         bitcnt = 0;
    logic [7:0] cur = 8'd0;
    logic       last_seen = 1'b1;
    logic       prev_sck = 1'b0;
    logic       prev_cs = 1'b1;
    logic       prev_mosi = 1'b0;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            bitcnt    = 0;
            last_seen = 1'b1;
            prev_sck  = 1'b0;
            prev_cs   = 1'b1;
            prev_mosi = 1'b0;
        end else begin
            if (sck && !prev_sck) begin
                rise_q.push_back(cyc);
                check("cs_low_at_rise", int'(cs_n), 0);
                cur = {cur[6:0], mosi};
                bitcnt++;
                if (bitcnt == 8) begin
                    bitcnt = 0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got 0x%02h expected no byte", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", int'(cur), int'(e[7:0]));
                        last_seen = e[8];
                    end
                end
            end
            if (!cs_n && prev_cs) begin
                cs_fall_cyc = cyc;
                fall_cnt++;
            end
            if (cs_n && !prev_cs) begin
                cs_rise_cyc = cyc;
                check("frame_partial_bits", bitcnt, 0);
                check("frame_ends_on_last", int'(last_seen), 1);
            end
            if (!cs_n && (mosi != prev_mosi))
                check("mosi_change_sck_low", int'(sck), 0);
            prev_sck  = sck;
            prev_cs   = cs_n;
            prev_mosi = mosi;
        end
    end

    // Offer one byte; returns the cycle in which the handshake was presented.
    task automatic send(input logic [7:0] d, input logic l, output int hc);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        hc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                hc = cyc;
                exp_q.push_back({l, d});
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout_fail("send_handshake");
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int rc);
        rc = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && tx_ready && (exp_q.size() == 0)) begin
                rc = cyc;
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout_fail("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 2000; i++) begin
            if (rise_q.size() >= n) return;
            @(negedge clk);
        end
        timeout_fail("wait_rises");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h1, h2, h3, rc, bad, fc0, gap;
        logic [7:0] d0, d1, d2;
        logic       l;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_sck", int'(sck), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_ready", int'(tx_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tx_ready", int'(tx_ready), 1);
        check("post_rst_busy", int'(busy), 0);
        $display("reset released: tx_ready=%0d busy=%0d", tx_ready, busy);

        // Single byte 0xA5 as a complete frame, with timing
        rise_q.delete();
        send(8'hA5, 1'b1, h1);
        tx_valid = 1'b0;
        wait_idle(rc);
        $display("xfer A5 last=1: hs=%0d fall=%0d rise=%0d ready=%0d", h1, cs_fall_cyc, cs_rise_cyc, rc);
        check("a5_cs_fall", cs_fall_cyc - h1, 1);
        check("a5_rise_count", rise_q.size(), 8);
        if (rise_q.size() >= 8) begin
            check("a5_first_rise", rise_q[0] - h1, 3);
            bad = 0;
            for (int i = 1; i < 8; i++) if (rise_q[i] - rise_q[i-1] != 2 * HALF) bad++;
            check("a5_rise_spacing", bad, 0);
        end
        check("a5_cs_low_len", cs_rise_cyc - cs_fall_cyc, BYTE_CYC + HALF);
        check("a5_ready_return", rc - cs_rise_cyc, 2 * HALF);

        // Two bytes streamed in one frame
        rise_q.delete();
        fc0 = fall_cnt;
        send(8'h3C, 1'b0, h1);
        send(8'hC3, 1'b1, h2);
        tx_valid = 1'b0;
        wait_idle(rc);
        $display("xfer 3C,C3: hs=%0d,%0d rises=%0d", h1, h2, rise_q.size());
        check("pair_rise_count", rise_q.size(), 16);
        bad = 0;
        for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 2 * HALF) bad++;
        check("pair_contiguous", bad, 0);
        check("pair_single_frame", fall_cnt - fc0, 1);

        // Starved stream parks in WAIT and resumes
        rise_q.delete();
        send(8'hFF, 1'b0, h1);
        tx_valid = 1'b0;
        wait_rises(8);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({cs_n, sck, mosi, busy} != 4'b0011) bad++;
        end
        check("wait_lines_parked", bad, 0);
        @(posedge clk);
        #1;
        send(8'h01, 1'b1, h2);
        tx_valid = 1'b0;
        wait_idle(rc);
        $display("xfer FF then 01 after wait: hs2=%0d rises=%0d", h2, rise_q.size());
        check("wait_rise_count", rise_q.size(), 16);
        if (rise_q.size() >= 9) check("wait_resume", rise_q[8] - h2, 3);

        // Backpressure with tx_valid held for three bytes
        rise_q.delete();
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        send(d0, 1'b0, h1);
        send(d1, 1'b0, h2);
        send(d2, 1'b1, h3);
        tx_valid = 1'b0;
        $display("xfer %02h,%02h,%02h backpressure: hs=%0d,%0d,%0d", d0, d1, d2, h1, h2, h3);
        check("bp_second_accept", h2 - h1, 1);
        check("bp_third_accept", h3 - h1, BYTE_CYC);
        wait_idle(rc);
        check("bp_rise_count", rise_q.size(), 24);

        // Reset in the middle of 0x55
        rise_q.delete();
        send(8'h55, 1'b1, h1);
        tx_valid = 1'b0;
        wait_rises(3);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("abort_cs_n", int'(cs_n), 1);
        check("abort_sck", int'(sck), 0);
        check("abort_mosi", int'(mosi), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_tx_ready", int'(tx_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_no_more_rises", rise_q.size(), 3);
        check("abort_ready_after", int'(tx_ready), 1);
        $display("xfer 55 aborted by reset after %0d rises", rise_q.size());
        rise_q.delete();
        send(8'h80, 1'b1, h1);
        tx_valid = 1'b0;
        wait_idle(rc);
        $display("xfer 80 after reset: rises=%0d", rise_q.size());
        check("fresh_rise_count", rise_q.size(), 8);

        // Random stream with idle gaps and noise on the data lines
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 4);
            if (gap > 0) begin
                tx_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    tx_data = 8'($urandom);
                    tx_last = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            d0 = 8'($urandom);
            l  = (i == 39) ? 1'b1 : ($urandom_range(0, 3) == 0);
            send(d0, l, h1);
            $display("xfer random %0d: data=%02h last=%0d hs=%0d", i, d0, l, h1);
        end
        tx_valid = 1'b0;
        wait_idle(rc);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
